// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl: AXI-Lite control front end for the FIR engine.
//
// Owns the ap_ctrl (0x00) and data_length (0x10) registers, sequences the engine through an
// idle/run/done flow and arbitrates the single-port tap BRAM between host AXI-Lite accesses
// (tap window 0x20 .. 0x20+4*Tape_Num-4) and engine coefficient fetches.
//
// Ports:
//   axis_clk, axis_rst_n           clock, asynchronous active-low reset
//   aw*/w*                         AXI-Lite write address/data (no B channel)
//   ar*/r*                         AXI-Lite read address/data
//   tap_WE/EN/Di/A, tap_Do         tap BRAM port (tap_Do has 1-cycle latency)
//   eng_start                      one-cycle start pulse to the engine
//   eng_tap_EN/A                   engine tap read request, owns the BRAM while running
//   eng_done                       engine finished pulse
//   data_length                    configured sample count
module fir_ap_ctrl #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   eng_start,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length
);

  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = '0;
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] TapLast  = pADDR_WIDTH'(32'h20 + 4 * (Tape_Num - 1));

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic                   live_q;       // low during reset and the first cycle after it
  logic                   wr_acc_q;     // a write was accepted last cycle
  logic                   eng_start_q;  // doubles as the readable ap_start bit
  logic                   rd_busy_q;
  logic                   rd_ph1_q;     // read address phase done, BRAM being accessed
  logic                   rd_tap_q;
  logic                   rd_ffff_q;
  logic                   rd_done_q;    // outstanding beat returned ap_done=1
  logic                   rvalid_q;
  logic                   rsel_q;       // first beat cycle of a tap read: forward tap_Do
  logic [pADDR_WIDTH-1:0] rd_addr_q;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] data_length_q;
  logic                   axi_en_q;
  logic [3:0]             axi_we_q;
  logic [pADDR_WIDTH-1:0] axi_a_q;
  logic [pDATA_WIDTH-1:0] axi_di_q;

  logic                   aw_hs, ar_hs, ar_rdy, run, wr_start, r_beat;
  logic                   aw_tap, ar_tap;
  logic [pDATA_WIDTH-1:0] ap_reg, rd_val;

  function automatic logic in_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TapBase) && (a <= TapLast);
  endfunction

  always_comb begin
    run      = (state_q == StRun);
    aw_hs    = live_q && awvalid && wvalid && !wr_acc_q;
    // Writes take priority over reads in the same cycle.
    ar_rdy   = live_q && !rd_busy_q && !aw_hs;
    ar_hs    = ar_rdy && arvalid;
    aw_tap   = in_tap(awaddr);
    ar_tap   = in_tap(araddr);
    wr_start = aw_hs && (awaddr == AddrCtrl) && wdata[0] && !run;
    r_beat   = rvalid_q && rready;

    ap_reg    = '0;
    ap_reg[0] = eng_start_q;
    ap_reg[1] = (state_q == StDone);
    ap_reg[2] = (state_q != StRun);

    rd_val = '0;
    if (rd_ffff_q) begin
      rd_val = '1;
    end else if (rd_addr_q == AddrCtrl) begin
      rd_val = ap_reg;
    end else if (rd_addr_q == AddrLen) begin
      rd_val = data_length_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (wr_start) state_d = StRun;
      StRun:  if (eng_done) state_d = StDone;
      StDone: begin
        // A new start wins over the ap_done read-clear.
        if (wr_start) begin
          state_d = StRun;
        end else if (r_beat && rd_done_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= StIdle;
      live_q        <= 1'b0;
      wr_acc_q      <= 1'b0;
      eng_start_q   <= 1'b0;
      rd_busy_q     <= 1'b0;
      rd_ph1_q      <= 1'b0;
      rd_tap_q      <= 1'b0;
      rd_ffff_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rsel_q        <= 1'b0;
      rd_addr_q     <= '0;
      rdata_q       <= '0;
      data_length_q <= '0;
      axi_en_q      <= 1'b0;
      axi_we_q      <= 4'h0;
      axi_a_q       <= '0;
      axi_di_q      <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      wr_acc_q    <= aw_hs;
      eng_start_q <= wr_start;
      axi_en_q    <= 1'b0;
      axi_we_q    <= 4'h0;

      // Writes in RUN to the tap window or data_length complete but are dropped.
      if (aw_hs && !run) begin
        if (awaddr == AddrLen) data_length_q <= wdata;
        if (aw_tap) begin
          axi_en_q <= 1'b1;
          axi_we_q <= 4'hF;
          axi_a_q  <= awaddr - TapBase;
          axi_di_q <= wdata;
        end
      end

      if (ar_hs) begin
        rd_busy_q <= 1'b1;
        rd_ph1_q  <= 1'b1;
        rd_addr_q <= araddr;
        rd_tap_q  <= ar_tap && !run;
        rd_ffff_q <= ar_tap && run;
        if (ar_tap && !run) begin
          axi_en_q <= 1'b1;
          axi_a_q  <= araddr - TapBase;
        end
      end

      if (rd_ph1_q) begin
        rd_ph1_q  <= 1'b0;
        rvalid_q  <= 1'b1;
        rsel_q    <= rd_tap_q;
        rdata_q   <= rd_val;
        rd_done_q <= (rd_addr_q == AddrCtrl) && (state_q == StDone);
      end

      if (rvalid_q) begin
        // Capture BRAM data so rdata stays stable while the host stalls.
        if (rsel_q) begin
          rdata_q <= tap_Do;
          rsel_q  <= 1'b0;
        end
        if (rready) begin
          rvalid_q  <= 1'b0;
          rd_busy_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    awready     = aw_hs;
    wready      = aw_hs;
    arready     = ar_rdy;
    rvalid      = rvalid_q;
    rdata       = rsel_q ? tap_Do : rdata_q;
    eng_start   = eng_start_q;
    data_length = data_length_q;
    if (run) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
      tap_WE = 4'h0;
      tap_Di = '0;
    end else begin
      tap_EN = axi_en_q;
      tap_A  = axi_a_q;
      tap_WE = axi_we_q;
      tap_Di = axi_di_q;
    end
  end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Scoreboard bench for fir_ap_ctrl: reads push their expected data at handshake time, a
// monitor pops and compares on every completed R beat. Includes a behavioural tap BRAM.
module tb_fir_ap_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        eng_start;
  logic        eng_tap_EN = 1'b0;
  logic [11:0] eng_tap_A = '0;
  logic        eng_done = 1'b0;
  logic [31:0] data_length;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[16];

  always #5 axis_clk = ~axis_clk;

  fir_ap_ctrl #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .Tape_Num   (11)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do),
    .eng_start  (eng_start),
    .eng_tap_EN (eng_tap_EN),
    .eng_tap_A  (eng_tap_A),
    .eng_done   (eng_done),
    .data_length(data_length)
  );

  // Single-port BRAM, 1-cycle read latency.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compare every completed R beat against the scoreboard.
  always @(negedge axis_clk) begin
    #2;
    if (axis_rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) flag_fail("r_unexpected_beat");
      else check("r_data", rdata, exp_q.pop_front());
    end
  end

  // mode: 0 none, 1 tap write visible on BRAM port, 2 nothing must happen, 3 start pulse
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input int mode);
    bit got = 0;
    @(negedge axis_clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (awready && wready) begin got = 1; break; end
      @(negedge axis_clk);
    end
    if (!got) begin
      flag_fail("wr_timeout");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge axis_clk);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    case (mode)
      1: begin
        check("tap_we_on", {28'h0, tap_WE}, 32'hF);
        check("tap_en_on", {31'h0, tap_EN}, 32'h1);
        check("tap_a_wr", {20'h0, tap_A}, {20'h0, a - 12'h20});
        check("tap_di_wr", tap_Di, d);
      end
      2: begin
        check("tap_we_run", {28'h0, tap_WE}, 32'h0);
        check("no_start", {31'h0, eng_start}, 32'h0);
      end
      3: check("start_pulse", {31'h0, eng_start}, 32'h1);
      default: ;
    endcase
    if (mode == 1 || mode == 3) begin
      @(negedge axis_clk);
      #1;
      if (mode == 1) check("tap_we_off", {28'h0, tap_WE}, 32'h0);
      else check("start_single", {31'h0, eng_start}, 32'h0);
    end
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] e, input bit push,
                          input bit wait_done);
    bit got = 0;
    @(negedge axis_clk);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (arready) begin got = 1; break; end
      @(negedge axis_clk);
    end
    if (!got) begin
      flag_fail("rd_addr_timeout");
      arvalid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(e);
    @(posedge axis_clk);
    @(negedge axis_clk);
    arvalid = 1'b0;
    #1;
    check("rd_lat_t1", {31'h0, rvalid}, 32'h0);
    @(negedge axis_clk);
    #1;
    check("rd_lat_t2", {31'h0, rvalid}, 32'h1);
    if (wait_done) begin
      got = 0;
      for (int n = 0; n < 20; n++) begin
        if (!rvalid) begin got = 1; break; end
        @(negedge axis_clk);
        #1;
      end
      if (!got) flag_fail("rd_beat_timeout");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {29'h0, awready, wready, arready}, 32'h0);
    check({tag, "_rvalid_start"}, {30'h0, rvalid, eng_start}, 32'h0);
    check({tag, "_tap_ctl"}, {27'h0, tap_WE, tap_EN}, 32'h0);
    check({tag, "_tap_a"}, {20'h0, tap_A}, 32'h0);
    check({tag, "_tap_di"}, tap_Di, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_data_length"}, data_length, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge axis_clk);
    #1;
    check_all_zero("reset");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;

    // Tap write/readback across the whole window
    for (int i = 0; i < 11; i++) axi_write(12'h20 + 12'(4 * i), 32'(i), 1);
    for (int i = 0; i < 11; i++) axi_read(12'h20 + 12'(4 * i), 32'(i), 1, 1);
    axi_read(12'h4C, 32'h0, 1, 1);  // just past the window
    axi_read(12'h00, 32'h4, 1, 1);  // idle after reset

    // Configure and start
    axi_write(12'h10, 32'd600, 0);
    check("data_length", data_length, 32'd600);
    axi_read(12'h10, 32'd600, 1, 1);
    axi_write(12'h00, 32'h1, 3);
    axi_read(12'h00, 32'h0, 1, 1);

    // RUN: host tap accesses blocked, engine owns the port
    axi_write(12'h24, 32'd99, 2);
    axi_read(12'h24, 32'hFFFF_FFFF, 1, 1);
    axi_write(12'h10, 32'd5, 2);
    check("data_length_run", data_length, 32'd600);
    axi_write(12'h00, 32'h1, 2);
    @(negedge axis_clk);
    eng_tap_EN = 1'b1; eng_tap_A = 12'h8;
    #1;
    check("eng_mux_en", {31'h0, tap_EN}, 32'h1);
    check("eng_mux_a", {20'h0, tap_A}, 32'h8);
    @(negedge axis_clk);
    eng_tap_EN = 1'b0; eng_tap_A = '0;

    // DONE and read-clear back to IDLE
    @(negedge axis_clk);
    eng_done = 1'b1;
    @(negedge axis_clk);
    eng_done = 1'b0;
    axi_read(12'h00, 32'h6, 1, 1);
    axi_read(12'h00, 32'h4, 1, 1);
    axi_read(12'h24, 32'h1, 1, 1);
    axi_read(12'h48, 32'd10, 1, 1);

    // Simultaneous write and read: write first, rdata held under back-pressure
    rready = 1'b0;
    @(negedge axis_clk);
    awaddr = 12'h28; wdata = 32'd77; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h28; arvalid = 1'b1;
    #1;
    check("simul_awready", {31'h0, awready}, 32'h1);
    check("simul_arready_blocked", {31'h0, arready}, 32'h0);
    @(posedge axis_clk);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("simul_arready_next", {31'h0, arready}, 32'h1);
    exp_q.push_back(32'd77);
    @(posedge axis_clk);
    @(negedge axis_clk);
    arvalid = 1'b0;
    #1;
    check("simul_rd_lat_t1", {31'h0, rvalid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge axis_clk);
      #1;
      check("hold_rvalid", {31'h0, rvalid}, 32'h1);
      check("hold_rdata", rdata, 32'd77);
    end
    @(negedge axis_clk);
    rready = 1'b1;
    @(negedge axis_clk);
    #1;
    check("hold_beat_done", {31'h0, rvalid}, 32'h0);

    // Reset during RUN with a read beat pending
    axi_write(12'h00, 32'h1, 3);
    rready = 1'b0;
    axi_read(12'h10, 32'd600, 0, 0);
    @(negedge axis_clk);
    axis_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    rready = 1'b1;
    axi_read(12'h00, 32'h4, 1, 1);
    axi_read(12'h10, 32'h0, 1, 1);

    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge axis_clk);
    end
    if (exp_q.size() != 0) flag_fail("scoreboard_not_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
